// File: rtl/center_of_mass.sv
// center_of_mass
//   Accumulates the coordinates of every masked pixel in a frame. On the
//   frame-end strobe it snapshots the sums and computes the floor-mean x/y
//   with two parallel 32-cycle restoring dividers. The centroid is then
//   presented with a one-cycle valid pulse.
//
// Parameters:
//   MIN_PIXELS  - minimum masked-pixel count for a frame to produce a centroid
//
// Ports:
//   clk_in       pixel clock
//   rst_in       synchronous active-high reset
//   x_in, y_in   pixel coordinate (11 / 10 bits)
//   valid_in     pixel on x_in/y_in/mask_in is valid
//   mask_in      threshold result for this pixel
//   tabulate_in  one-cycle frame-end strobe
//   x_out, y_out centroid (held between updates)
//   valid_out    one-cycle pulse when x_out/y_out update
//   busy_out     high while the divider runs
//
// Optional feature (macro COM_BBOX_EN):
//   adds xmin_out/xmax_out (11 bits) and ymin_out/ymax_out (10 bits), the
//   bounding box of the masked pixels, updated together with x_out/y_out.

module center_of_mass #(
  parameter int unsigned MIN_PIXELS = 1
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [10:0] x_in,
  input  logic [9:0]  y_in,
  input  logic        valid_in,
  input  logic        mask_in,
  input  logic        tabulate_in,
  output logic [10:0] x_out,
  output logic [9:0]  y_out,
  output logic        valid_out,
  output logic        busy_out
`ifdef COM_BBOX_EN
  ,
  output logic [10:0] xmin_out,
  output logic [10:0] xmax_out,
  output logic [9:0]  ymin_out,
  output logic [9:0]  ymax_out
`endif
);

  localparam logic [19:0] MIN_CNT = 20'(MIN_PIXELS);

  typedef enum logic [1:0] {IDLE, DIVIDE, DONE} state_t;

  state_t      state;

  // running accumulators
  logic [31:0] x_sum, y_sum;
  logic [19:0] count;

  // divider registers: the quotient shifts into the dividend register
  logic [31:0] x_quo, y_quo;
  logic [19:0] x_rem, y_rem;
  logic [19:0] div_count;
  logic [4:0]  step_cnt;

  logic        pix;
  logic [31:0] x_sum_nxt, y_sum_nxt;
  logic [19:0] count_nxt;

  logic [20:0] x_trial, y_trial;
  logic        x_ge, y_ge;
  logic [19:0] x_rem_step, y_rem_step;
  logic [31:0] x_quo_step, y_quo_step;

  always_comb begin
    pix       = valid_in & mask_in;
    x_sum_nxt = x_sum + (pix ? {21'd0, x_in} : 32'd0);
    y_sum_nxt = y_sum + (pix ? {22'd0, y_in} : 32'd0);
    count_nxt = count + {19'd0, pix};
  end

  // One restoring-division step per cycle. The remainder is always below the
  // divisor, so the 20-bit wrap-around difference is exact whenever x_ge holds.
  always_comb begin
    x_trial    = {x_rem, x_quo[31]};
    y_trial    = {y_rem, y_quo[31]};
    x_ge       = (x_trial >= {1'b0, div_count});
    y_ge       = (y_trial >= {1'b0, div_count});
    x_rem_step = x_ge ? (x_trial[19:0] - div_count) : x_trial[19:0];
    y_rem_step = y_ge ? (y_trial[19:0] - div_count) : y_trial[19:0];
    x_quo_step = {x_quo[30:0], x_ge};
    y_quo_step = {y_quo[30:0], y_ge};
  end

`ifdef COM_BBOX_EN
  logic [10:0] run_xmin, run_xmax, snap_xmin, snap_xmax;
  logic [9:0]  run_ymin, run_ymax, snap_ymin, snap_ymax;
  logic [10:0] run_xmin_nxt, run_xmax_nxt;
  logic [9:0]  run_ymin_nxt, run_ymax_nxt;

  always_comb begin
    run_xmin_nxt = (pix && (x_in < run_xmin)) ? x_in : run_xmin;
    run_xmax_nxt = (pix && (x_in > run_xmax)) ? x_in : run_xmax;
    run_ymin_nxt = (pix && (y_in < run_ymin)) ? y_in : run_ymin;
    run_ymax_nxt = (pix && (y_in > run_ymax)) ? y_in : run_ymax;
  end
`endif

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state     <= IDLE;
      x_sum     <= '0;
      y_sum     <= '0;
      count     <= '0;
      x_quo     <= '0;
      y_quo     <= '0;
      x_rem     <= '0;
      y_rem     <= '0;
      div_count <= '0;
      step_cnt  <= '0;
      x_out     <= '0;
      y_out     <= '0;
      valid_out <= 1'b0;
      busy_out  <= 1'b0;
`ifdef COM_BBOX_EN
      run_xmin  <= '1;
      run_xmax  <= '0;
      run_ymin  <= '1;
      run_ymax  <= '0;
      snap_xmin <= '1;
      snap_xmax <= '0;
      snap_ymin <= '1;
      snap_ymax <= '0;
      xmin_out  <= '1;
      xmax_out  <= '0;
      ymin_out  <= '1;
      ymax_out  <= '0;
`endif
    end else begin
      // accumulation runs in every state; a tabulate in IDLE overrides it
      x_sum     <= x_sum_nxt;
      y_sum     <= y_sum_nxt;
      count     <= count_nxt;
      valid_out <= 1'b0;
`ifdef COM_BBOX_EN
      run_xmin  <= run_xmin_nxt;
      run_xmax  <= run_xmax_nxt;
      run_ymin  <= run_ymin_nxt;
      run_ymax  <= run_ymax_nxt;
`endif
      case (state)
        IDLE: begin
          if (tabulate_in) begin
            // snapshot includes a pixel arriving this cycle; next frame starts empty
            x_quo     <= x_sum_nxt;
            y_quo     <= y_sum_nxt;
            div_count <= count_nxt;
            x_rem     <= '0;
            y_rem     <= '0;
            step_cnt  <= '0;
            x_sum     <= '0;
            y_sum     <= '0;
            count     <= '0;
`ifdef COM_BBOX_EN
            snap_xmin <= run_xmin_nxt;
            snap_xmax <= run_xmax_nxt;
            snap_ymin <= run_ymin_nxt;
            snap_ymax <= run_ymax_nxt;
            run_xmin  <= '1;
            run_xmax  <= '0;
            run_ymin  <= '1;
            run_ymax  <= '0;
`endif
            if (count_nxt >= MIN_CNT) begin
              state    <= DIVIDE;
              busy_out <= 1'b1;
            end
          end
        end

        DIVIDE: begin
          x_quo    <= x_quo_step;
          y_quo    <= y_quo_step;
          x_rem    <= x_rem_step;
          y_rem    <= y_rem_step;
          step_cnt <= step_cnt + 5'd1;
          if (step_cnt == 5'd31) begin
            // outputs load on the final step so they are visible during DONE
            state     <= DONE;
            busy_out  <= 1'b0;
            valid_out <= 1'b1;
            x_out     <= x_quo_step[10:0];
            y_out     <= y_quo_step[9:0];
`ifdef COM_BBOX_EN
            xmin_out  <= snap_xmin;
            xmax_out  <= snap_xmax;
            ymin_out  <= snap_ymin;
            ymax_out  <= snap_ymax;
`endif
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_center_of_mass.sv
// Directed self-checking bench for center_of_mass.
module tb_center_of_mass;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic [10:0] x_in = '0;
  logic [9:0]  y_in = '0;
  logic        valid_in = 1'b0;
  logic        mask_in = 1'b0;
  logic        tabulate_in = 1'b0;
  logic [10:0] x_out;
  logic [9:0]  y_out;
  logic        valid_out;
  logic        busy_out;
`ifdef COM_BBOX_EN
  logic [10:0] xmin_out, xmax_out;
  logic [9:0]  ymin_out, ymax_out;
`endif

  int unsigned checks = 0;
  int unsigned errors = 0;

  center_of_mass #(.MIN_PIXELS(1)) dut (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .x_in        (x_in),
    .y_in        (y_in),
    .valid_in    (valid_in),
    .mask_in     (mask_in),
    .tabulate_in (tabulate_in),
    .x_out       (x_out),
    .y_out       (y_out),
    .valid_out   (valid_out),
    .busy_out    (busy_out)
`ifdef COM_BBOX_EN
    ,
    .xmin_out    (xmin_out),
    .xmax_out    (xmax_out),
    .ymin_out    (ymin_out),
    .ymax_out    (ymax_out)
`endif
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic pixel(input int unsigned x, input int unsigned y, input logic v, input logic m);
    x_in = 11'(x); y_in = 10'(y); valid_in = v; mask_in = m;
    step();
    valid_in = 1'b0; mask_in = 1'b0;
  endtask

  // tabulate strobe, optionally with a masked pixel in the same cycle
  task automatic start_tab(input logic with_pix, input int unsigned x, input int unsigned y);
    tabulate_in = 1'b1;
    x_in = 11'(x); y_in = 10'(y); valid_in = with_pix; mask_in = with_pix;
    step();
    tabulate_in = 1'b0; valid_in = 1'b0; mask_in = 1'b0;
  endtask

  // Called right after start_tab. Checks 32 busy cycles then the DONE cycle.
  // At loop index inj_idx a masked pixel plus a tabulate strobe are injected.
  task automatic run_div(input string tag, input int unsigned ex, input int unsigned ey,
                         input int inj_idx, input int unsigned ix, input int unsigned iy);
    int unsigned busy_cnt = 0;
    int unsigned early_valid = 0;
    for (int i = 0; i < 32; i++) begin
      if (busy_out) busy_cnt++;
      if (valid_out) early_valid++;
      if (i == inj_idx) begin
        tabulate_in = 1'b1; valid_in = 1'b1; mask_in = 1'b1;
        x_in = 11'(ix); y_in = 10'(iy);
      end
      step();
      tabulate_in = 1'b0; valid_in = 1'b0; mask_in = 1'b0;
    end
    check({tag, " busy_cycles"}, busy_cnt, 32);
    check({tag, " early_valid"}, early_valid, 0);
    check({tag, " valid"}, 32'(valid_out), 1);
    check({tag, " busy_done"}, 32'(busy_out), 0);
    check({tag, " x"}, 32'(x_out), ex);
    check({tag, " y"}, 32'(y_out), ey);
  endtask

  task automatic after_done(input string tag);
    step();
    check({tag, " valid_drop"}, 32'(valid_out), 0);
  endtask

  // after start_tab: frame must not produce a result; outputs must hold
  task automatic no_run(input string tag, input int unsigned ex, input int unsigned ey);
    int unsigned act = 0;
    for (int i = 0; i < 36; i++) begin
      if (busy_out || valid_out) act++;
      step();
    end
    check({tag, " activity"}, act, 0);
    check({tag, " x_hold"}, 32'(x_out), ex);
    check({tag, " y_hold"}, 32'(y_out), ey);
  endtask

  initial begin
    int unsigned act;

    // reset
    step(); step();
    rst_in = 1'b0;
    check("rst x", 32'(x_out), 0);
    check("rst y", 32'(y_out), 0);
    check("rst valid", 32'(valid_out), 0);
    check("rst busy", 32'(busy_out), 0);
`ifdef COM_BBOX_EN
    check("rst xmin", 32'(xmin_out), 2047);
    check("rst xmax", 32'(xmax_out), 0);
    check("rst ymin", 32'(ymin_out), 1023);
    check("rst ymax", 32'(ymax_out), 0);
`endif

    // single pixel
    pixel(100, 50, 1'b1, 1'b1);
    start_tab(1'b0, 0, 0);
    run_div("single", 100, 50, -1, 0, 0);
    after_done("single");

    // floor division; an invalid pixel with mask high must be ignored
    pixel(10, 3, 1'b1, 1'b1);
    pixel(1000, 700, 1'b0, 1'b1);
    pixel(13, 4, 1'b1, 1'b1);
    pixel(900, 600, 1'b1, 1'b0);
    start_tab(1'b0, 0, 0);
    run_div("floor", 11, 3, -1, 0, 0);
    after_done("floor");

    // empty frame
    start_tab(1'b0, 0, 0);
    no_run("empty", 11, 3);

    // pixel in the tabulate cycle belongs to the snapshot frame only
    pixel(200, 100, 1'b1, 1'b1);
    start_tab(1'b1, 300, 300);
    run_div("same_cycle", 250, 200, -1, 0, 0);
    after_done("same_cycle");
    start_tab(1'b0, 0, 0);
    no_run("cleared", 250, 200);

    // tabulate during DIVIDE and during DONE is ignored
    pixel(20, 20, 1'b1, 1'b1);
    start_tab(1'b0, 0, 0);
    run_div("frame_a", 20, 20, 5, 40, 40);
    start_tab(1'b0, 0, 0);
    check("done_tab busy", 32'(busy_out), 0);
    check("done_tab valid", 32'(valid_out), 0);
    start_tab(1'b0, 0, 0);
    run_div("frame_b", 40, 40, -1, 0, 0);
    after_done("frame_b");

    // bounding-box frame (centroid 7,4)
    pixel(5, 7, 1'b1, 1'b1);
    pixel(9, 2, 1'b1, 1'b1);
    start_tab(1'b0, 0, 0);
    run_div("bbox", 7, 4, -1, 0, 0);
`ifdef COM_BBOX_EN
    check("bbox xmin", 32'(xmin_out), 5);
    check("bbox xmax", 32'(xmax_out), 9);
    check("bbox ymin", 32'(ymin_out), 2);
    check("bbox ymax", 32'(ymax_out), 7);
`endif
    after_done("bbox");

    // large frame: every x across 64 full rows y=352..415; means 511.5/383.5
    valid_in = 1'b1; mask_in = 1'b1;
    for (int y = 352; y < 416; y++) begin
      for (int x = 0; x < 1024; x++) begin
        x_in = 11'(x); y_in = 10'(y);
        step();
      end
    end
    valid_in = 1'b0; mask_in = 1'b0;
    start_tab(1'b0, 0, 0);
    run_div("large", 511, 383, -1, 0, 0);
    after_done("large");

    // reset mid-DIVIDE
    pixel(300, 200, 1'b1, 1'b1);
    start_tab(1'b0, 0, 0);
    for (int i = 0; i < 9; i++) step();
    rst_in = 1'b1;
    step();
    rst_in = 1'b0;
    check("rst_mid x", 32'(x_out), 0);
    check("rst_mid y", 32'(y_out), 0);
    check("rst_mid busy", 32'(busy_out), 0);
    check("rst_mid valid", 32'(valid_out), 0);
    act = 0;
    for (int i = 0; i < 40; i++) begin
      if (valid_out || busy_out) act++;
      step();
    end
    check("rst_mid no_valid", act, 0);
    start_tab(1'b0, 0, 0);
    no_run("rst_mid cleared", 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/center_of_mass.md
# center_of_mass

Downstream consumer of the HSV threshold stage's per-pixel mask. It accumulates the coordinates of every masked pixel in a frame. On a frame-end strobe it computes the floor-mean x and y with an iterative divider and presents the centroid to the overlay and tracking logic. It sits between the threshold mask and the crosshair/AR overlay in the video pipeline.

## Interface
Parameters:
- `MIN_PIXELS`, default 1: minimum masked-pixel count for a frame to produce a centroid.

Ports:
- `clk_in` — input, 1 bit. Pixel clock; the only clock.
- `rst_in` — input, 1 bit. Reset, synchronous, active-high.
- `x_in` — input, 11 bits. Horizontal pixel coordinate, 0..1023.
- `y_in` — input, 10 bits. Vertical pixel coordinate, 0..767.
- `valid_in` — input, 1 bit. Pixel on `x_in`/`y_in`/`mask_in` is valid this cycle.
- `mask_in` — input, 1 bit. Threshold result for this pixel.
- `tabulate_in` — input, 1 bit. One-cycle frame-end strobe.
- `x_out` — output, 11 bits. Centroid x.
- `y_out` — output, 10 bits. Centroid y.
- `valid_out` — output, 1 bit. One-cycle pulse when `x_out`/`y_out` update.
- `busy_out` — output, 1 bit. High while the divider runs.

## Operation
- Accumulators:
  - `x_sum` is 32 bits, `y_sum` is 32 bits, `count` is 20 bits.
  - Sizing covers a full 1024×768 frame with every pixel masked: 1024·768·1023 < 2^30. No saturation logic is required.
- A pixel is accumulated when `valid_in && mask_in`: `x_sum += x_in`, `y_sum += y_in`, `count += 1`.
- Accumulation continues in every state, including DIVIDE.
- States:
  - **IDLE**
    - On `tabulate_in`, snapshot `x_sum`, `y_sum` and `count` into the divider registers, including any pixel accumulated in the same cycle.
    - In the same cycle, clear the accumulators; a pixel arriving in the tabulate cycle counts toward the snapshot frame only.
    - If snapshot count ≥ `MIN_PIXELS`, go to DIVIDE. Otherwise stay in IDLE; no `valid_out`, and outputs hold.
  - **DIVIDE**
    - Two parallel restoring dividers: x_sum/count and y_sum/count.
    - One quotient bit per cycle, MSB first, 32 cycles.
    - `tabulate_in` in this state is ignored: no snapshot, and the accumulators are not cleared, so the next frame absorbs those pixels.
    - Then go to DONE.
  - **DONE** (one cycle)
    - `x_out` ← quotient_x[10:0], `y_out` ← quotient_y[9:0].
    - Truncation is lossless because mean ≤ max coordinate.
    - Assert `valid_out`, then return to IDLE.
- Division is floor division; the remainder is discarded.
- `x_out`/`y_out` hold their last value between updates.

## Timing
- Reset values:
  - `x_out` = 0, `y_out` = 0, `valid_out` = 0, `busy_out` = 0.
  - All accumulators and divider registers = 0; state = IDLE.
- `tabulate_in` sampled high at edge T (IDLE, count OK):
  - `busy_out` is high from T+1 through T+32.
  - `valid_out` and new outputs appear at T+33 for exactly one cycle.
- Back-to-back: `tabulate_in` at T+33 (DONE cycle) is ignored. It is first honoured at T+34 (IDLE).
- `rst_in` mid-DIVIDE: abort, return to reset values the next cycle, no `valid_out`.
- `mask_in` is ignored when `valid_in` = 0.

## Configuration
- `COM_BBOX_EN` defined:
  - Adds ports `xmin_out`/`xmax_out` (11 bits) and `ymin_out`/`ymax_out` (10 bits).
  - Running min/max are tracked over masked pixels and snapshotted with the sums.
  - They update in the DONE cycle alongside `x_out`/`y_out`.
  - Reset values: min = all-ones, max = 0. Running min/max reset to the same values when cleared at tabulate.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

## Test plan
- **Single pixel**: mask at (100, 50), tabulate at T → `valid_out` at T+33, `x_out` = 100, `y_out` = 50, `busy_out` high T+1..T+32.
- **Floor division**: masks at (10,3) and (13,4), tabulate → `x_out` = 11, `y_out` = 3.
- **Empty frame**: no masked pixels, tabulate → no `valid_out` and no `busy_out`; outputs keep their prior values.
- **Full frame, all pixels masked**: 1024×768 pixels, tabulate → `x_out` = 511, `y_out` = 383 (no overflow).
- **Tabulate during DIVIDE**:
  - Frame A = (20,20), tabulate. During DIVIDE, mask (40,40), then a second tabulate that is ignored.
  - Tabulate again in IDLE → `x_out` = 40, `y_out` = 40.
- **Reset mid-DIVIDE**: `rst_in` at T+10 → outputs 0, `valid_out` never pulses. With `COM_BBOX_EN` on a separate run: masks (5,7), (9,2) → xmin/xmax = 5/9, ymin/ymax = 2/7.
